// File: rtl/sprite_pixel_streamer.sv
// Reads a rectangular sprite from a sync-read BRAM in row-major order and streams tagged pixels.
// The first pixel is valid two edges after the accepting start edge; a 2-slot return FIFO absorbs pixel_ready stalls.
module sprite_pixel_streamer #(
    parameter int unsigned SPR_AW      = 12,
    parameter logic [7:0]  TRANSPARENT = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       cmd_x,
    input  logic [10:0]       cmd_y,
    input  logic [10:0]       cmd_w_m1,
    input  logic [10:0]       cmd_h_m1,
    input  logic [SPR_AW-1:0] cmd_base,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [SPR_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [10:0]       width,
    output logic [10:0]       height,
    output logic [10:0]       pixel_x,
    output logic [10:0]       pixel_y,
    output logic [7:0]        pixel_data,
    output logic              draw,
    output logic              pixel_valid,
    input  logic              pixel_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  data;
        logic        draw;
    } pix_t;

    localparam logic [SPR_AW-1:0] ADDR_ONE = {{(SPR_AW-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [10:0]       x0_q;
    logic [10:0]       w_q;
    logic [10:0]       h_q;
    logic [10:0]       rd_x_q;
    logic [10:0]       rd_y_q;
    logic [10:0]       tag_x_q;
    logic [10:0]       tag_y_q;
    logic [SPR_AW-1:0] addr_q;
    logic [21:0]       rem_q;
    logic              inflight_q;
    pix_t              fifo_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;

    logic              push;
    logic              pop;
    logic [21:0]       w_ext;
    logic [21:0]       h_ext;
    logic [21:0]       total_m1;
    pix_t              ret_entry;
    pix_t              head;

    // Product is taken mod 2^22, so a full 2048x2048 job still yields 2^22-1.
    assign w_ext    = {11'd0, cmd_w_m1} + 22'd1;
    assign h_ext    = {11'd0, cmd_h_m1} + 22'd1;
    assign total_m1 = (w_ext * h_ext) - 22'd1;

    assign push  = inflight_q;
    assign pop   = (cnt_q != 2'd0) && pixel_ready;
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    // A pop in the same cycle frees a credit, so a ready-high stream has no bubbles.
    assign rom_en = (state_q == FETCH) &&
                    ((cnt_q + {1'b0, inflight_q} - {1'b0, pop}) < 2'd2);

    assign ret_entry = '{x: tag_x_q, y: tag_y_q, data: rom_data,
                         draw: (rom_data != TRANSPARENT)};
    assign head      = fifo_q[rd_ptr_q];

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_addr    = addr_q;
    assign width       = w_q;
    assign height      = h_q;
    assign pixel_valid = (cnt_q != 2'd0);
    assign pixel_x     = head.x;
    assign pixel_y     = head.y;
    assign pixel_data  = head.data;
    assign draw        = head.draw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            tag_x_q    <= '0;
            tag_y_q    <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rom_en;
            cnt_q      <= cnt_d;

            if (push) begin
                fifo_q[wr_ptr_q] <= ret_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            if (rom_en) begin
                tag_x_q <= rd_x_q;
                tag_y_q <= rd_y_q;
                addr_q  <= addr_q + ADDR_ONE;
                rem_q   <= rem_q - 22'd1;
                if (rd_x_q == x0_q + w_q) begin
                    rd_x_q <= x0_q;
                    rd_y_q <= rd_y_q + 11'd1;
                end else begin
                    rd_x_q <= rd_x_q + 11'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q    <= cmd_x;
                        w_q     <= cmd_w_m1;
                        h_q     <= cmd_h_m1;
                        rd_x_q  <= cmd_x;
                        rd_y_q  <= cmd_y;
                        addr_q  <= cmd_base;
                        rem_q   <= total_m1;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (rom_en && (rem_q == 22'd0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish on the edge that retires the last pixel.
                    if (!inflight_q && (cnt_d == 2'd0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_pixel_streamer.sv
// Directed jobs with randomized BRAM contents and pixel_ready, checked against a queue model
// of the row-major sprite walk.
`timescale 1ns/1ps
module tb_sprite_pixel_streamer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] cmd_x, cmd_y, cmd_w_m1, cmd_h_m1;
    logic [11:0] cmd_base;
    logic        busy, done, rom_en;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [10:0] width, height, pixel_x, pixel_y;
    logic [7:0]  pixel_data;
    logic        draw, pixel_valid, pixel_ready;

    logic [7:0]  rom_mem [4096];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  d;
        logic        dr;
    } exp_t;
    exp_t exp_q[$];

    sprite_pixel_streamer #(.SPR_AW(12), .TRANSPARENT(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w_m1(cmd_w_m1), .cmd_h_m1(cmd_h_m1),
        .cmd_base(cmd_base), .busy(busy), .done(done), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .width(width), .height(height),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data), .draw(draw),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_pixel_valid"}, pixel_valid, 0);
        chk({tag, "_pixel_xy"}, {pixel_x, pixel_y}, 0);
        chk({tag, "_pixel_data_draw"}, {pixel_data, draw}, 0);
        chk({tag, "_width_height"}, {width, height}, 0);
    endtask

    task automatic run_job(input logic [10:0] x, input logic [10:0] y,
                           input logic [10:0] w, input logic [10:0] h,
                           input logic [11:0] base, input bit rnd_ready,
                           input bit inject, input int abort_after);
        int   total, issued, hs, cyc, first_valid, vcycles, last_hs;
        bit   held, finished, aborted;
        exp_t held_e, e;

        exp_q.delete();
        for (int j = 0; j <= int'(h); j++) begin
            for (int i = 0; i <= int'(w); i++) begin
                e.x  = 11'((int'(x) + i) % 2048);
                e.y  = 11'((int'(y) + j) % 2048);
                e.d  = rom_mem[(int'(base) + j * (int'(w) + 1) + i) % 4096];
                e.dr = (e.d != 8'h00);
                exp_q.push_back(e);
            end
        end
        total = exp_q.size();
        issued = 0; hs = 0; first_valid = -1; vcycles = 0; last_hs = -1;
        held = 0; finished = 0; aborted = 0;

        @(negedge clk);
        cmd_x = x; cmd_y = y; cmd_w_m1 = w; cmd_h_m1 = h; cmd_base = base;
        start = 1'b1;
        pixel_ready = 1'b1;

        for (cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                cmd_x = 11'($urandom); cmd_y = 11'($urandom);
                cmd_w_m1 = 11'($urandom); cmd_h_m1 = 11'($urandom);
                cmd_base = 12'($urandom);
            end
            if (inject && cyc == 4) begin
                start = 1'b1;
                cmd_w_m1 = w + 11'd3; cmd_h_m1 = h + 11'd1; cmd_base = base + 12'h40;
            end
            if (inject && cyc == 5) start = 1'b0;
            pixel_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (busy) chk("geometry_stable", {width, height}, {w, h});
            if (rom_en) begin
                chk("rom_addr", rom_addr, (int'(base) + issued) % 4096);
                issued++;
            end
            if (held) begin
                chk("hold_valid", pixel_valid, 1);
                chk("hold_pixel", {pixel_x, pixel_y, pixel_data, draw},
                    {held_e.x, held_e.y, held_e.d, held_e.dr});
            end
            if (pixel_valid) begin
                vcycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_xy", {pixel_x, pixel_y}, {e.x, e.y});
                    chk("pixel_data_draw", {pixel_data, draw}, {e.d, e.dr});
                end
                hs++;
                last_hs = cyc;
            end
            held = pixel_valid && !pixel_ready;
            held_e.x = pixel_x; held_e.y = pixel_y; held_e.d = pixel_data; held_e.dr = draw;
            chk("outstanding_le_2", (issued - hs) <= 2, 1);
            if (abort_after >= 0 && hs == abort_after) begin
                aborted = 1;
                break;
            end
            if (done) begin
                chk("pixel_count_at_done", hs, total);
                chk("done_after_last_hs", cyc, last_hs + 1);
                chk("busy_low_with_done", busy, 0);
                finished = 1;
                break;
            end
        end

        if (aborted) begin
            @(posedge clk);
            #2 reset = 1'b1;
            #1 check_reset_outputs("abort_reset");
            @(negedge clk);
            reset = 1'b0;
            pixel_ready = 1'b1;
            repeat (8) begin
                @(negedge clk);
                #1 chk("post_abort_quiet", {busy, done, pixel_valid, rom_en}, 0);
            end
        end else begin
            chk("job_done_within_bound", finished, 1);
            if (!rnd_ready && !inject) begin
                // start sampled on the edge ending cycle 0; valid two edges later
                chk("first_valid_latency", first_valid, 3);
                chk("valid_cycles", vcycles, total);
                chk("no_bubbles", last_hs - first_valid + 1, total);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w_m1 = '0; cmd_h_m1 = '0; cmd_base = '0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        rom_mem[12'h010] = 8'h3C;
        run_job(11'd5, 11'd7, 11'd0, 11'd0, 12'h010, 1'b0, 1'b0, -1);
        run_job(11'd100, 11'd200, 11'd2, 11'd1, 12'h000, 1'b0, 1'b0, -1);
        run_job(11'd300, 11'd40, 11'd19, 11'd0, 12'h100, 1'b1, 1'b0, -1);

        for (int i = 0; i < 8; i++) rom_mem[12'h200 + i] = (i % 2 == 1) ? 8'h7F : 8'h00;
        run_job(11'd10, 11'd10, 11'd3, 11'd1, 12'h200, 1'b1, 1'b0, -1);

        run_job(11'd50, 11'd60, 11'd5, 11'd2, 12'h300, 1'b1, 1'b1, -1);
        run_job(11'd2045, 11'd2046, 11'd4, 11'd3, 12'hFFD, 1'b1, 1'b0, -1);

        repeat (3) begin
            run_job(11'($urandom), 11'($urandom), 11'($urandom_range(0, 7)),
                    11'($urandom_range(0, 5)), 12'($urandom), 1'($urandom_range(0, 1)),
                    1'b0, -1);
        end

        run_job(11'd0, 11'd0, 11'd3, 11'd2, 12'h400, 1'b1, 1'b0, 4);
        run_job(11'd1, 11'd2, 11'd1, 11'd1, 12'h500, 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
